// File: rtl/mat_mac_accumulator.sv
// Dot-product accumulator for the matrix-multiply datapath.
// Sums N signed products per C element and hands it off with its linear address.
module mat_mac_accumulator #(
  parameter int DATA_W        = 8,
  parameter int ACC_W         = 24,
  parameter int N             = 4,
  parameter int OUT_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        a_data,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [OUT_ADDR_BITS-1:0] out_addr,
  output logic                     done
);

  localparam int KW = $clog2(N);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [KW-1:0] K_LAST =
    KW'(N - 1);
  localparam logic [OUT_ADDR_BITS-1:0] E_LAST =
    OUT_ADDR_BITS'(N * N - 1);

  logic [0:0]               state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]         out_data_q, out_data_d;
  logic [OUT_ADDR_BITS-1:0] out_addr_q, out_addr_d;
  logic [OUT_ADDR_BITS-1:0] elem_q, elem_d;
  logic                     done_q, done_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    p;
  logic signed [ACC_W-1:0]    sum;
  logic                       in_take;
  logic                       out_take;

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign done      = done_q;

  assign in_take  = in_valid && in_ready;
  assign out_take = out_valid && out_ready;

  assign prod = $signed(a_data) * $signed(b_data);
  assign p    = ACC_W'(prod);

  // First beat of an element restarts the sum instead of adding to it.
  assign sum = (k_q == '0) ? p : acc_q + p;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    elem_d     = elem_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_ACC: begin
        if (in_take) begin
          acc_d = sum;
          if (k_q == K_LAST) begin
            out_data_d = sum;
            out_addr_d = elem_q;
            k_d        = '0;
            state_d    = S_HOLD;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_take) begin
          state_d = S_ACC;
          if (elem_q == E_LAST) begin
            elem_d = '0;
            done_d = 1'b1;
          end else begin
            elem_d = elem_q + OUT_ADDR_BITS'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ACC;
      k_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      elem_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      elem_q     <= elem_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mat_mac_accumulator.sv
// Bench for mat_mac_accumulator: vector table, corner sequences,
// and random traffic against a plain-arithmetic dot-product model.
module tb_mat_mac_accumulator;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] a_data = '0;
  logic signed [7:0] b_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [23:0]       out_data;
  logic [3:0]        out_addr;
  logic              done;

  int total = 0;
  int bad   = 0;
  int exp_addr = 0;

  mat_mac_accumulator #(
    .DATA_W(8), .ACC_W(24), .N(4), .OUT_ADDR_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    string             nm;
    logic [3:0][7:0]   a;
    logic [3:0][7:0]   b;
    logic [23:0]       exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic signed [7:0] a,
                      input logic signed [7:0] b);
    in_valid = 1'b1;
    a_data   = a;
    b_data   = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    exp_addr = 0;
  endtask

  // Checks a presented element, performs the handshake, checks done.
  task automatic take(input string nm, input logic [23:0] exp);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, 32'(out_data), 32'(exp));
    chk({nm, "_addr"}, 32'(out_addr), 32'(exp_addr));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_vlow"}, 32'(out_valid), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'(exp_addr == 15));
    exp_addr = (exp_addr + 1) % 16;
  endtask

  task automatic ones_elem();
    for (int i = 0; i < 4; i++) push(8'sd1, 8'sd1);
  endtask

  initial begin
    logic signed [7:0] ra[4];
    logic signed [7:0] rb[4];
    int s;
    logic [23:0] hold_v;
    int gap;

    vecs[0] = '{"basic", {8'd4, 8'd3, 8'd2, 8'd1},
                {8'd8, 8'd7, 8'd6, 8'd5}, 24'd70};
    vecs[1] = '{"negpos", {4{8'h80}}, {4{8'h7f}}, 24'hFF0200};
    vecs[2] = '{"negneg", {4{8'h80}}, {4{8'h80}}, 24'h010000};
    vecs[3] = '{"maxmax", {4{8'h7f}}, {4{8'h7f}}, 24'h00FC04};
    vecs[4] = '{"cancel", {8'hff, 8'h01, 8'hff, 8'h01},
                {4{8'h01}}, 24'h000000};

    // Reset with in_valid high and random operands
    in_valid = 1'b1;
    a_data = 8'($urandom);
    b_data = 8'($urandom);
    rst = 1'b1;
    tick();
    a_data = 8'($urandom);
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_addr = 0;
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid2", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Vector table, back-to-back beats
    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        push($signed(vecs[v].a[i]), $signed(vecs[v].b[i]));
        if (i < 3)
          chk({vecs[v].nm, "_early"}, 32'(out_valid), 32'd0);
      end
      take(vecs[v].nm, vecs[v].exp);
    end

    // Gapped beats, then backpressure with new data offered
    for (int i = 0; i < 4; i++) begin
      push(8'sd2, 8'sd3);
      idle(1);
    end
    in_valid = 1'b1;
    a_data = 8'sd9;
    b_data = 8'sd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'd24);
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    take("bp", 24'd24);
    ones_elem();
    take("post_bp", 24'd4);

    // Full matrix from a clean start
    do_reset(1);
    for (int e = 0; e < 16; e++) begin
      ones_elem();
      take("full", 24'd4);
    end
    tick();
    chk("done_once", 32'(done), 32'd0);
    ones_elem();
    take("wrap", 24'd4);

    // Reset in the middle of an accumulation
    do_reset(1);
    push(8'sd10, 8'sd10);
    push(8'sd10, 8'sd10);
    do_reset(1);
    ones_elem();
    take("midrst", 24'd4);

    // Reset while a result is held under backpressure
    ones_elem();
    chk("hold_valid", 32'(out_valid), 32'd1);
    do_reset(1);
    chk("hold_rst", 32'(out_valid), 32'd0);

    // Random traffic against a plain dot-product model
    do_reset(1);
    for (int e = 0; e < 40; e++) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
        s += int'(ra[i]) * int'(rb[i]);
      end
      for (int i = 0; i < 4; i++) begin
        push(ra[i], rb[i]);
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          a_data = 8'($urandom);
          tick();
        end
      end
      hold_v = 24'(s);
      gap = $urandom_range(0, 3);
      in_valid = 1'b1;
      for (int g = 0; g < gap; g++) begin
        a_data = 8'($urandom);
        b_data = 8'($urandom);
        chk("rnd_hold", 32'(out_data), 32'(hold_v));
        tick();
      end
      in_valid = 1'b0;
      take("rnd", hold_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
